// File: rtl/dsm_cic_decim.sv
// Third-order CIC decimator: 1-bit delta-sigma stream in, offset-binary words out.
// Integrators run at the bit rate, combs at the decimated rate.
module dsm_cic_decim #(
   parameter int DECIM     = 32,
   parameter int OUT_WIDTH = 16
) (
   input  logic                 aclk,
   input  logic                 arst_n,
   input  logic                 s_axis_data_tdata,
   input  logic                 s_axis_data_tvalid,
   output logic                 s_axis_data_tready,
   output logic [OUT_WIDTH-1:0] m_axis_data_tdata,
   output logic                 m_axis_data_tvalid,
   input  logic                 m_axis_data_tready,
   output logic                 overrun
);

   localparam int LOG2  = $clog2(DECIM);
   localparam int ACC_W = 3*LOG2 + 2;
   localparam int SHIFT = 3*LOG2 - (OUT_WIDTH-1);
   localparam int CNT_W = LOG2;

   localparam logic signed [ACC_W-1:0] Y_MAX =
      ACC_W'((1 << (OUT_WIDTH-1)) - 1);
   localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

   logic [ACC_W-1:0] i1;
   logic [ACC_W-1:0] i2;
   logic [ACC_W-1:0] i3;
   logic [ACC_W-1:0] i3_nxt;
   logic [ACC_W-1:0] x;
   logic [CNT_W-1:0] cnt;
   logic             beat;
   logic             strobe;

   logic [ACC_W-1:0] cap;
   logic             cap_v;
   logic [ACC_W-1:0] d1;
   logic [ACC_W-1:0] d2;
   logic [ACC_W-1:0] d3;
   logic [ACC_W-1:0] c1;
   logic [ACC_W-1:0] c2;
   logic [ACC_W-1:0] c3;
   logic [ACC_W-1:0] c3_q;
   logic             c3_v;
   logic [1:0]       warm;

   logic signed [ACC_W-1:0]     y_sh;
   logic        [OUT_WIDTH-1:0] y_sat;
   logic        [OUT_WIDTH-1:0] y_ob;
   logic                        load;
   logic                        accept;

   assign beat   = s_axis_data_tvalid & s_axis_data_tready;
   assign strobe = beat & (cnt == CNT_W'(DECIM-1));
   assign x      = s_axis_data_tdata ? ACC_W'(1) : '1;
   assign i3_nxt = i3 + i2;

   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         s_axis_data_tready <= 1'b0;
         i1    <= '0;
         i2    <= '0;
         i3    <= '0;
         cnt   <= '0;
         cap   <= '0;
         cap_v <= 1'b0;
      end else begin
         s_axis_data_tready <= 1'b1;
         cap_v              <= strobe;
         if (beat) begin
            i1  <= i1 + x;
            i2  <= i2 + i1;
            i3  <= i3_nxt;
            cnt <= cnt + CNT_W'(1);
         end
         if (strobe) begin
            cap <= i3_nxt;
         end
      end
   end

   assign c1 = cap - d1;
   assign c2 = c1 - d2;
   assign c3 = c2 - d3;

   // Start-up comb results see partial history; hold them back.
   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         d1   <= '0;
         d2   <= '0;
         d3   <= '0;
         c3_q <= '0;
         c3_v <= 1'b0;
         warm <= 2'd0;
      end else begin
         c3_v <= 1'b0;
         if (cap_v) begin
            d1   <= cap;
            d2   <= c1;
            d3   <= c2;
            c3_q <= c3;
            if (warm == 2'd3) begin
               c3_v <= 1'b1;
            end else begin
               warm <= warm + 2'd1;
            end
         end
      end
   end

   always_comb begin
      y_sh  = $signed(c3_q) >>> SHIFT;
      y_sat = y_sh[OUT_WIDTH-1:0];
      if (y_sh > Y_MAX) begin
         y_sat = Y_MAX[OUT_WIDTH-1:0];
      end else if (y_sh < Y_MIN) begin
         y_sat = Y_MIN[OUT_WIDTH-1:0];
      end
      y_ob = {~y_sat[OUT_WIDTH-1], y_sat[OUT_WIDTH-2:0]};
   end

   assign accept = m_axis_data_tvalid & m_axis_data_tready;
   assign load   = c3_v & (~m_axis_data_tvalid | m_axis_data_tready);

   // A full, stalled output register wins over a new sample.
   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         m_axis_data_tdata  <= '0;
         m_axis_data_tvalid <= 1'b0;
         overrun            <= 1'b0;
      end else begin
         if (load) begin
            m_axis_data_tdata  <= y_ob;
            m_axis_data_tvalid <= 1'b1;
         end else if (accept) begin
            m_axis_data_tvalid <= 1'b0;
         end
         if (c3_v & ~load) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dsm_cic_decim.sv
// Bench for dsm_cic_decim: sinc^3 FIR reference model feeding a scoreboard,
// table of constant-density vectors plus step, backpressure and reset sequences.
module tb_dsm_cic_decim;

   localparam int R  = 32;
   localparam int OW = 16;
   localparam int SH = 3*$clog2(R) - (OW-1);
   localparam int NG = 3*R - 2;

   logic          clk = 1'b0;
   logic          arst_n = 1'b0;
   logic          s_tdata = 1'b0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic [OW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_ready = 1'b1;
   logic          overrun;

   dsm_cic_decim #(.DECIM(R), .OUT_WIDTH(OW)) dut (
      .aclk               (clk),
      .arst_n             (arst_n),
      .s_axis_data_tdata  (s_tdata),
      .s_axis_data_tvalid (s_tvalid),
      .s_axis_data_tready (s_tready),
      .m_axis_data_tdata  (m_tdata),
      .m_axis_data_tvalid (m_tvalid),
      .m_axis_data_tready (m_ready),
      .overrun            (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OW-1:0] data;
      int            cyc;
   } exp_t;

   typedef struct {
      string         name;
      logic [3:0]    pat;
      bit            gap;
      logic [OW-1:0] steady;
   } vec_t;

   exp_t          q[$];
   exp_t          mon_e;
   int            hist[$];
   int            g[0:NG-1];
   int            nb = 0;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   int            nwords = 0;
   int            steady_exp = -1;
   bit            mon_en = 1'b0;
   bit            bp = 1'b0;
   logic [OW-1:0] last_word = '0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [OW-1:0] exp_word();
      longint y;
      longint ys;
      int n;
      y = 0;
      n = hist.size() - 1;
      for (int k = 0; k < NG; k++) begin
         if (n - 2 - k >= 0) y += longint'(g[k]) * hist[n-2-k];
      end
      ys = y >>> SH;
      if (ys > (2**(OW-1)) - 1) ys = (2**(OW-1)) - 1;
      if (ys < -(2**(OW-1))) ys = -(2**(OW-1));
      return OW'(ys + 2**(OW-1));
   endfunction

   task automatic model_beat(input logic b);
      exp_t e;
      hist.push_back(b ? 1 : -1);
      nb++;
      if (nb % R == 0 && nb / R >= 4) begin
         e.data = exp_word();
         e.cyc  = bp ? -1 : cyc + 3;
         q.push_back(e);
      end
   endtask

   task automatic drive(input logic b, input logic v, output bit took);
      @(negedge clk);
      s_tdata  = b;
      s_tvalid = v;
      took     = v && s_tready;
      if (took) model_beat(b);
   endtask

   task automatic drain(input int n);
      bit t;
      repeat (n) drive(1'b0, 1'b0, t);
   endtask

   task automatic run(input logic [3:0] pat, input int nbeats, input bit gap);
      int  i;
      int  guard;
      bit  t;
      logic v;
      i = 0;
      guard = 0;
      while (i < nbeats && guard < 20*nbeats) begin
         v = gap ? logic'($urandom_range(0, 1)) : 1'b1;
         drive(pat[3 - (i % 4)], v, t);
         if (t) i++;
         guard++;
      end
      if (i < nbeats) chk("run_timeout", i, nbeats);
   endtask

   task automatic do_reset();
      @(negedge clk);
      mon_en   = 1'b0;
      arst_n   = 1'b0;
      s_tvalid = 1'b0;
      @(negedge clk);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_tready", s_tready, 0);
      chk("rst_tdata", m_tdata, 0);
      q.delete();
      hist.delete();
      nb      = 0;
      bp      = 1'b0;
      m_ready = 1'b1;
      arst_n  = 1'b1;
      mon_en  = 1'b1;
      @(negedge clk);
      chk("rel_tready", s_tready, 1);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         #2;
         if (m_tvalid && m_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", m_tdata, cyc);
            end else begin
               mon_e = q.pop_front();
               chk("word_data", m_tdata, mon_e.data);
               if (mon_e.cyc >= 0) chk("word_latency", cyc, mon_e.cyc);
               if (steady_exp >= 0) chk("word_steady", m_tdata, steady_exp);
               last_word = m_tdata;
               nwords++;
            end
         end
      end
   end

   vec_t vt[5];
   int   b2[0:2*R-2];
   int   nw0;
   logic [OW-1:0] held;

   initial begin
      foreach (b2[k]) b2[k] = 0;
      for (int i = 0; i < R; i++)
         for (int j = 0; j < R; j++) b2[i+j]++;
      for (int k = 0; k < NG; k++) begin
         g[k] = 0;
         for (int i = 0; i < R; i++)
            if (k - i >= 0 && k - i <= 2*R-2) g[k] += b2[k-i];
      end

      vt[0] = '{"ones",   4'b1111, 1'b0, 16'hFFFF};
      vt[1] = '{"zeros",  4'b0000, 1'b0, 16'h0000};
      vt[2] = '{"alt",    4'b1010, 1'b0, 16'h8000};
      vt[3] = '{"d75",    4'b1110, 1'b0, 16'hC000};
      vt[4] = '{"d75gap", 4'b1110, 1'b1, 16'hC000};

      for (int v = 0; v < 5; v++) begin
         do_reset();
         steady_exp = int'(vt[v].steady);
         nw0 = nwords;
         run(vt[v].pat, 6*R, vt[v].gap);
         drain(6);
         chk({vt[v].name, "_words"}, nwords - nw0, 3);
         chk({vt[v].name, "_last"}, last_word, vt[v].steady);
         chk({vt[v].name, "_qempty"}, q.size(), 0);
         steady_exp = -1;
      end

      // density step 75% -> 50%
      do_reset();
      nw0 = nwords;
      run(4'b1110, 4*R, 1'b0);
      run(4'b0101, 3*R, 1'b0);
      drain(6);
      chk("step_words", nwords - nw0, 4);
      chk("step_settled", last_word, 16'h8000);

      // backpressure across two strobes, then mid-frame reset
      do_reset();
      run(4'b1110, 5*R, 1'b0);
      drain(4);
      @(negedge clk);
      m_ready = 1'b0;
      bp      = 1'b1;
      run(4'b1111, R, 1'b0);
      drain(4);
      chk("bp_held_valid", m_tvalid, 1);
      held = q[0].data;
      chk("bp_held_data", m_tdata, held);
      chk("bp_no_overrun_yet", overrun, 0);
      run(4'b1111, R, 1'b0);
      drain(4);
      void'(q.pop_back());
      chk("bp_overrun", overrun, 1);
      chk("bp_still_valid", m_tvalid, 1);
      chk("bp_data_stable", m_tdata, held);
      @(negedge clk);
      m_ready = 1'b1;
      bp      = 1'b0;
      drain(1);
      chk("bp_accepted_once", m_tvalid, 0);
      chk("bp_overrun_sticky", overrun, 1);
      chk("bp_qempty", q.size(), 0);
      drain(4);
      @(negedge clk);
      m_ready = 1'b0;
      bp      = 1'b1;
      run(4'b1111, R + 10, 1'b0);
      chk("pre_rst_valid", m_tvalid, 1);
      do_reset();
      nw0 = nwords;
      steady_exp = 16'hFFFF;
      run(4'b1111, 4*R - 1, 1'b0);
      drain(6);
      chk("post_rst_none_early", nwords - nw0, 0);
      run(4'b1111, 1, 1'b0);
      drain(6);
      chk("post_rst_first", nwords - nw0, 1);
      chk("post_rst_qempty", q.size(), 0);
      steady_exp = -1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
